// File: rtl/wakey_pkg.sv
// Shared constants for the wakey_wakey PDM mic link: sample width, decimation ratio and
// the dither LFSR definition used by the transmitter model.
package wakey_pkg;

  localparam int PCM_W_DEF = 16;
  localparam int PDM_OSR   = 250;

  localparam int LFSR_W = 16;
  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask (bit 15 = tap 16).
  localparam lfsr_t LFSR_TAPS = 16'hB400;

  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pdm_tx_fifo.sv
// Small synchronous sample FIFO for the PDM transmitter: registered ready, level output and a
// flush input that empties the queue and blocks pushes while asserted.
module pdm_tx_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       ready_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          do_push, do_pop;

  // Ready is the registered handshake, so a full FIFO never accepts even when popping.
  assign do_push = push_i & ready_q & ~flush_i;
  assign do_pop  = pop_i & (level_q != '0) & ~flush_i;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    ready_d = ~flush_i & (level_d != LW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_q];
  assign ready_o = ready_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/pdm_mic_emulator.sv
// PDM microphone model: buffers PCM samples and emits a first-order sigma-delta bit stream
// stepped on falling edges of the receiver's pdm_clk. Optional dither: define PDM_DITHER_EN.
module pdm_mic_emulator
  import wakey_pkg::*;
#(
  parameter int PCM_W      = PCM_W_DEF,
  parameter int OSR        = PDM_OSR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          clr_i,
  input  logic signed [PCM_W-1:0]       s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic                          pdm_clk_i,
  output logic                          pdm_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          underrun_o
);

  localparam int ACC_W = PCM_W + 2;
  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic signed [ACC_W-1:0] FS =
    {{(ACC_W-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] mod_step(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [PCM_W-1:0] smp,
    input logic signed [ACC_W-1:0] dith
  );
    logic signed [ACC_W-1:0] smp_ext;
    smp_ext = {{(ACC_W-PCM_W){smp[PCM_W-1]}}, smp};
    return acc[ACC_W-1] ? acc + smp_ext + FS + dith : acc + smp_ext - FS + dith;
  endfunction

  logic                    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                    step;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PCM_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    data_q, data_d;
  logic                    underrun_q, underrun_d;
  logic                    und_set;
  logic                    pop;
  logic                    fifo_empty;
  logic [PCM_W-1:0]        fifo_rdata;
  logic signed [PCM_W-1:0] head;
  logic signed [ACC_W-1:0] dith;

  pdm_tx_fifo #(.W(PCM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (~enable_i),
    .push_i  (s_valid_i & s_ready_o),
    .wdata_i (s_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .ready_o (s_ready_o),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign head = $signed(fifo_rdata);

  // Two-flop synchronizer; a step is a falling edge seen on the synchronized copy.
  always_comb begin
    sync1_d = pdm_clk_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign step = enable_i & prev_q & ~sync2_q;

`ifdef PDM_DITHER_EN
  lfsr_t lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (!enable_i)  lfsr_d = LFSR_SEED;
    else if (step)  lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign dith = {{(ACC_W-4){lfsr_q[3]}}, lfsr_q[3:0]};
`else
  assign dith = '0;
`endif

  always_comb begin
    acc_d   = acc_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    data_d  = data_q;
    pop     = 1'b0;
    und_set = 1'b0;
    if (step) begin
      data_d = ~acc_q[ACC_W-1];
      if (!busy_q && !fifo_empty) begin
        // Loading from idle: this step is already step 0 of the new sample.
        pop    = 1'b1;
        busy_d = 1'b1;
        cur_d  = head;
        cnt_d  = CNT_W'(1);
        acc_d  = mod_step(acc_q, head, dith);
      end else begin
        acc_d = mod_step(acc_q, cur_q, dith);
        if (busy_q) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!fifo_empty) begin
              pop   = 1'b1;
              cur_d = head;
            end else begin
              cur_d   = '0;
              busy_d  = 1'b0;
              und_set = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    end
    if (!enable_i) begin
      acc_d  = '0;
      cur_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
      data_d = 1'b0;
      pop    = 1'b0;
    end
    underrun_d = und_set | (underrun_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      acc_q      <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign pdm_data_o = data_q;
  assign busy_o     = busy_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Self-checking bench for pdm_mic_emulator: per-sample bit streams scored against a
// first-order sigma-delta reference, plus FIFO, underrun, disable and reset sequences.
module tb_pdm_mic_emulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               clr = 1'b0;
  logic signed [15:0] s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               pdm_clk = 1'b1;
  logic               pdm_data;
  logic [2:0]         level;
  logic               busy;
  logic               underrun;

  int n_tests = 0;
  int n_fail  = 0;

  bit pdm_run = 0;
  int div = 0;
  int nrise = 0;
  int rise_target = 0;
  int ones = 0;
  int macc = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  pdm_mic_emulator dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .clr_i        (clr),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .pdm_clk_i    (pdm_clk),
    .pdm_data_o   (pdm_data),
    .fifo_level_o (level),
    .busy_o       (busy),
    .underrun_o   (underrun)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    n_tests++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Reference sigma-delta: queue the expected bits for n steps of one sample value.
  task automatic gen(input int smp, input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = (macc >= 0);
      macc = macc + smp - (b ? 32768 : -32768);
      exp_q.push_back(b);
    end
  endtask

  // PDM clock (period 8 clk); receiver-style sampling on each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (pdm_run) begin
        div++;
        if (div == 4) begin
          div = 0;
          pdm_clk = ~pdm_clk;
          if (pdm_clk) begin
            nrise++;
            ones += int'(pdm_data);
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL sb_empty: got bit %0d at rise %0d, expected none", pdm_data, nrise);
            end else begin
              chk($sformatf("pdm_bit%0d", nrise), pdm_data, exp_q.pop_front());
            end
            if (nrise >= rise_target) pdm_run = 0;
          end
        end
      end
    end
  end

  task automatic run_steps(input int n);
    nrise = 0;
    ones = 0;
    div = 0;
    rise_target = n;
    pdm_run = 1;
    for (int i = 0; i < n * 8 + 40 && pdm_run; i++) @(posedge clk);
    if (pdm_run) begin
      pdm_run = 0;
      chk("run_timeout", nrise, n);
    end
    @(negedge clk);
  endtask

  task automatic try_push(input logic signed [15:0] d, output bit ok);
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    ok = s_ready;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    macc = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    logic signed [15:0] smp;
    int                 min_ones;
    int                 max_ones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int acc_cnt;

    vecs[0] = '{16'sd0,      125, 125};
    vecs[1] = '{16'sd32767,  249, 250};
    vecs[2] = '{-16'sd32768, 0,   1};
    vecs[3] = '{16'sd16384,  187, 188};
    vecs[4] = '{-16'sd16384, 62,  63};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pdm_data", pdm_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 1);
    rst_n = 1'b1;

    // One sample per vector, 250 steps, then the underrun boundary.
    for (int v = 0; v < 5; v++) begin
      restart();
      pulse_clr();
      gen(vecs[v].smp, 250);
      try_push(vecs[v].smp, ok);
      chk($sformatf("v%0d_push", v), ok, 1);
      @(negedge clk);
      chk($sformatf("v%0d_level", v), level, 1);
      chk($sformatf("v%0d_busy_pre", v), busy, 0);
      run_steps(250);
      chk_range($sformatf("v%0d_ones", v), ones, vecs[v].min_ones, vecs[v].max_ones);
      chk($sformatf("v%0d_underrun", v), underrun, 1);
      chk($sformatf("v%0d_busy_post", v), busy, 0);
    end

    // FIFO fills with no pdm_clk: 4 accepted, 5th refused.
    restart();
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      try_push(16'(i), ok);
      acc_cnt += int'(ok);
    end
    @(negedge clk);
    chk("full_accepted", acc_cnt, 4);
    chk("full_ready", s_ready, 0);
    chk("full_level", level, 4);
    chk("full_busy", busy, 0);

    // Back-to-back samples: reload at the boundary, no underrun until the queue drains.
    restart();
    pulse_clr();
    gen(32767, 250);
    gen(-32768, 250);
    try_push(16'sd32767, ok);
    try_push(-16'sd32768, ok);
    run_steps(250);
    chk("b2b_busy_mid", busy, 1);
    chk("b2b_underrun_mid", underrun, 0);
    chk("b2b_level_mid", level, 0);
    run_steps(250);
    chk_range("b2b_ones_neg", ones, 0, 1);
    chk("b2b_underrun_end", underrun, 1);

    // Disable mid-sample: flush, silence, underrun kept; restart begins with a 1.
    restart();
    gen(0, 101);
    try_push(16'sd0, ok);
    try_push(16'sd0, ok);
    try_push(16'sd0, ok);
    run_steps(101);
    chk("dis_pre_data", pdm_data, 1);
    chk("dis_pre_level", level, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_level", level, 0);
    chk("dis_data", pdm_data, 0);
    chk("dis_busy", busy, 0);
    chk("dis_underrun_kept", underrun, 1);
    chk("dis_ready", s_ready, 0);
    exp_q.delete();
    restart();
    gen(0, 4);
    try_push(16'sd0, ok);
    run_steps(4);

    // Underrun after one zero sample, silence keeps 1010, clr clears the flag.
    restart();
    pulse_clr();
    chk("ur_cleared_start", underrun, 0);
    gen(0, 254);
    try_push(16'sd0, ok);
    run_steps(254);
    chk("ur_set", underrun, 1);
    chk("ur_busy", busy, 0);
    pulse_clr();
    chk("ur_clr", underrun, 0);

    // Asynchronous reset mid-stream, then no spurious step after release.
    restart();
    gen(0, 3);
    try_push(16'sd0, ok);
    try_push(16'sd0, ok);
    run_steps(3);
    chk("mr_pre_data", pdm_data, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_pdm_data", pdm_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_level", level, 0);
    chk("mr_ready", s_ready, 1);
    chk("mr_underrun", underrun, 0);
    pdm_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_no_step_data", pdm_data, 0);
    chk("mr_no_step_busy", busy, 0);
    pdm_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
